bram_fu_arbiter: RTL

//  Shares one bram_fu instance between one writer and two readers (A, B) in the MMM block.

---
 rtl/bram_fu_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/bram_fu_arbiter.sv
// Shares one bram_fu between a pass-through writer and two round-robin readers (A, B).
// Each reader gets a 1-cycle-latency response backed by a one-entry hold register.
module bram_fu_arbiter #(
    parameter int addr_width = 9,
    parameter int data_width = 1024
) (
    input  logic                  CLK,
    input  logic                  RST_N,

    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [addr_width-1:0] wr_addr,
    input  logic [data_width-1:0] wr_data,

    input  logic                  rda_valid,
    output logic                  rda_ready,
    input  logic [addr_width-1:0] rda_addr,
    output logic                  rda_rsp_valid,
    input  logic                  rda_rsp_ready,
    output logic [data_width-1:0] rda_rsp_data,

    input  logic                  rdb_valid,
    output logic                  rdb_ready,
    input  logic [addr_width-1:0] rdb_addr,
    output logic                  rdb_rsp_valid,
    input  logic                  rdb_rsp_ready,
    output logic [data_width-1:0] rdb_rsp_data,

    output logic                  bram_write_en,
    output logic [addr_width-1:0] bram_write_addr,
    output logic [data_width-1:0] bram_write_data,
    output logic                  bram_read_en,
    output logic [addr_width-1:0] bram_read_addr,
    input  logic [data_width-1:0] bram_read_data
);

    localparam int n_clients = 2;
    localparam int client_a  = 0;
    localparam int client_b  = 1;

    logic [n_clients-1:0]                 req_valid;
    logic [n_clients-1:0]                 rsp_ready;
    logic [n_clients-1:0]                 cand;
    logic [n_clients-1:0]                 grant;
    logic [n_clients-1:0]                 rsp_valid;
    logic [n_clients-1:0][data_width-1:0] rsp_data;
    logic                                 last_grant_b_reg;

    assign req_valid[client_a] = rda_valid;
    assign req_valid[client_b] = rdb_valid;
    assign rsp_ready[client_a] = rda_rsp_ready;
    assign rsp_ready[client_b] = rdb_rsp_ready;

    // Writes never contend with reads: bram_fu has separate write and read ports.
    assign wr_ready        = 1'b1;
    assign bram_write_en   = wr_valid;
    assign bram_write_addr = wr_addr;
    assign bram_write_data = wr_data;

    generate
        for (genvar gi = 0; gi < n_clients; gi++) begin : client_g
            logic                  pend_reg;
            logic                  hold_reg;
            logic [data_width-1:0] hold_data_reg;
            logic                  elig;

            // A client may be granted only if its previous response leaves this cycle.
            assign elig          = !hold_reg && !(pend_reg && !rsp_ready[gi]);
            assign cand[gi]      = req_valid[gi] && elig;
            assign rsp_valid[gi] = pend_reg || hold_reg;
            assign rsp_data[gi]  = hold_reg ? hold_data_reg : bram_read_data;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    pend_reg      <= 1'b0;
                    hold_reg      <= 1'b0;
                    hold_data_reg <= '0;
                end else begin
                    pend_reg <= grant[gi];
                    // bram_fu read_data is only stable for one cycle, so park it if unconsumed.
                    if (pend_reg && !rsp_ready[gi]) begin
                        hold_reg      <= 1'b1;
                        hold_data_reg <= bram_read_data;
                    end else if (hold_reg && rsp_ready[gi]) begin
                        hold_reg <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    // Grants are suppressed while reset is asserted so no request is acknowledged then.
    always_comb begin
        grant = '0;
        if (RST_N) begin
            if (&cand) begin
                grant = last_grant_b_reg ? 2'b01 : 2'b10;
            end else begin
                grant = cand;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_grant_b_reg <= 1'b1;
        end else if (|grant) begin
            last_grant_b_reg <= grant[client_b];
        end
    end

    assign rda_ready      = grant[client_a];
    assign rdb_ready      = grant[client_b];
    assign bram_read_en   = |grant;
    assign bram_read_addr = grant[client_b] ? rdb_addr : rda_addr;

    assign rda_rsp_valid  = rsp_valid[client_a];
    assign rda_rsp_data   = rsp_data[client_a];
    assign rdb_rsp_valid  = rsp_valid[client_b];
    assign rdb_rsp_data   = rsp_data[client_b];

endmodule
